// File: rtl/axi_rd_arbiter_if.sv
// AXI3 read-channel bundle (AR + R) shared by the arbiter's upstream and downstream ports.
interface axi_rd_arbiter_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [1:0]            arlock;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock,
        output arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Upstream requesters carry no lock attribute.
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot,
        input  arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI3 read arbiter, one transaction in flight, beat-count checking.
// Define AXI_RD_ARB_RR_EN for round-robin; default is fixed priority with M1 first.
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axi_rd_arbiter_if.slave       m0,
    axi_rd_arbiter_if.slave       m1,
    axi_rd_arbiter_if.master      s,
    output logic                  grant,
    output logic                  idle,
    output logic                  burst_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic                  pick1;
    logic                  ar_acc;
    logic                  r_hs;
    logic [3:0]            beat_cnt;
    logic [ID_WIDTH-1:0]   arid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [3:0]            arlen_q;
    logic [2:0]            arsize_q;
    logic [1:0]            arburst_q;
    logic [3:0]            arcache_q;
    logic [2:0]            arprot_q;

`ifdef AXI_RD_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr set means M1 wins the next tie.
    always_ff @(posedge aclk) begin
        if (!aresetn) rr_ptr <= 1'b0;
        else if (ar_acc) rr_ptr <= ~pick1;
    end

    assign pick1 = m1.arvalid & (~m0.arvalid | rr_ptr);
`else
    assign pick1 = m1.arvalid;
`endif

    assign ar_acc = (state == IDLE) & (m0.arvalid | m1.arvalid);
    assign r_hs   = (state == DATA) & s.rvalid & s.rready;

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ar_acc) state_nx = ADDR;
            ADDR:    if (s.arready) state_nx = DATA;
            DATA:    if (r_hs && s.rlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rid     = '0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rlast   = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rid     = '0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rlast   = 1'b0;
        unique case (state)
            IDLE: begin
                m0.arready = m0.arvalid & ~pick1;
                m1.arready = pick1;
            end
            ADDR: s.arvalid = 1'b1;
            DATA: begin
                if (grant) begin
                    m1.rvalid = s.rvalid;
                    m1.rid    = s.rid;
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rlast  = s.rlast;
                    s.rready  = m1.rready;
                end else begin
                    m0.rvalid = s.rvalid;
                    m0.rid    = s.rid;
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rlast  = s.rlast;
                    s.rready  = m0.rready;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arcache_q <= '0;
            arprot_q  <= '0;
            grant     <= 1'b0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            if (ar_acc) begin
                arid_q    <= pick1 ? m1.arid    : m0.arid;
                araddr_q  <= pick1 ? m1.araddr  : m0.araddr;
                arlen_q   <= pick1 ? m1.arlen   : m0.arlen;
                arsize_q  <= pick1 ? m1.arsize  : m0.arsize;
                arburst_q <= pick1 ? m1.arburst : m0.arburst;
                arcache_q <= pick1 ? m1.arcache : m0.arcache;
                arprot_q  <= pick1 ? m1.arprot  : m0.arprot;
                grant     <= pick1;
                beat_cnt  <= pick1 ? m1.arlen : m0.arlen;
            end
            if (r_hs) begin
                if (beat_cnt != 4'd0) beat_cnt <= beat_cnt - 4'd1;
                // Error when rlast disagrees with the remaining count.
                if (s.rlast != (beat_cnt == 4'd0)) burst_err <= 1'b1;
            end
        end
    end

    assign s.arid    = arid_q;
    assign s.araddr  = araddr_q;
    assign s.arlen   = arlen_q;
    assign s.arsize  = arsize_q;
    assign s.arburst = arburst_q;
    assign s.arcache = arcache_q;
    assign s.arprot  = arprot_q;
    assign s.arlock  = 2'b00;
    assign idle      = (state == IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (both arbitration builds).
module tb_axi_rd_arbiter;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic grant, idle, burst_err;
    int   n_cmp = 0;
    int   n_err = 0;
    int   idx;
    logic w1;

    localparam logic [11:0] ATTR0 = {3'd2, 2'd1, 4'h3, 3'd4};
    localparam logic [11:0] ATTR1 = {3'd2, 2'd2, 4'hF, 3'd0};
`ifdef AXI_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    axi_rd_arbiter_if m0_if ();
    axi_rd_arbiter_if m1_if ();
    axi_rd_arbiter_if s_if ();

    axi_rd_arbiter dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .grant     (grant),
        .idle      (idle),
        .burst_err (burst_err)
    );

    always #5 aclk = ~aclk;

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [31:0] addr,
                       input logic [3:0] len);
        if (w) begin
            m1_if.arvalid = 1'b1;
            m1_if.araddr  = addr;
            m1_if.arlen   = len;
        end else begin
            m0_if.arvalid = 1'b1;
            m0_if.araddr  = addr;
            m0_if.arlen   = len;
        end
    endtask

    // Accept winner w in IDLE, optionally stall downstream AR, end in DATA.
    task automatic ar_accept(input logic w, input logic [31:0] addr,
                             input logic [3:0] len, input int stall);
        #1;
        chk("arready_win", w ? m1_if.arready : m0_if.arready, 1);
        chk("arready_lose", w ? m0_if.arready : m1_if.arready, 0);
        s_if.arready = (stall == 0);
        step;
        if (w) m1_if.arvalid = 1'b0;
        else m0_if.arvalid = 1'b0;
        chk("grant", grant, w);
        chk("idle_busy", idle, 0);
        chk("s_arvalid_rise", s_if.arvalid, 1);
        chk("s_araddr", s_if.araddr, addr);
        chk("s_arlen", s_if.arlen, len);
        chk("s_arid", s_if.arid, w ? 4'h9 : 4'h5);
        chk("s_arattr", {s_if.arsize, s_if.arburst, s_if.arcache, s_if.arprot},
            w ? ATTR1 : ATTR0);
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_arvalid", s_if.arvalid, 1);
            chk("stall_araddr", s_if.araddr, addr);
            chk("stall_m0_arready", m0_if.arready, 0);
            chk("stall_m1_arready", m1_if.arready, 0);
            step;
        end
        s_if.arready = 1'b1;
        step;
        chk("s_arvalid_fall", s_if.arvalid, 0);
    endtask

    // Beats 0..last_at, rlast on last_at, both rready high.
    task automatic burst(input logic w, input int last_at, input logic [7:0] tag);
        m0_if.rready = 1'b1;
        m1_if.rready = 1'b1;
        for (int i = 0; i <= last_at; i++) begin
            s_if.rvalid = 1'b1;
            s_if.rdata  = {16'h0, tag, i[7:0]};
            s_if.rid    = w ? 4'h9 : 4'h5;
            s_if.rresp  = 2'b00;
            s_if.rlast  = (i == last_at);
            #1;
            chk("rvalid_route", w ? m1_if.rvalid : m0_if.rvalid, 1);
            chk("rdata_route", w ? m1_if.rdata : m0_if.rdata, {16'h0, tag, i[7:0]});
            chk("rvalid_other", w ? m0_if.rvalid : m1_if.rvalid, 0);
            chk("rdata_other", w ? m0_if.rdata : m1_if.rdata, 0);
            step;
        end
        chk("idle_after_rlast", idle, 1);
        chk("rvalid_outside", w ? m1_if.rvalid : m0_if.rvalid, 0);
        chk("s_rready_outside", s_if.rready, 0);
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
    endtask

    initial begin
        m0_if.arvalid = 0; m0_if.arid = 4'h5; m0_if.araddr = 0; m0_if.arlen = 0;
        {m0_if.arsize, m0_if.arburst, m0_if.arcache, m0_if.arprot} = ATTR0;
        m0_if.arlock = 0; m0_if.rready = 0;
        m1_if.arvalid = 0; m1_if.arid = 4'h9; m1_if.araddr = 0; m1_if.arlen = 0;
        {m1_if.arsize, m1_if.arburst, m1_if.arcache, m1_if.arprot} = ATTR1;
        m1_if.arlock = 0; m1_if.rready = 0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rid = 0;
        s_if.rdata = 0; s_if.rresp = 0; s_if.rlast = 0;

        repeat (2) step;
        chk("rst_idle", idle, 1);
        chk("rst_s_arvalid", s_if.arvalid, 0);
        chk("rst_s_araddr", s_if.araddr, 0);
        chk("rst_s_arlen", s_if.arlen, 0);
        chk("rst_grant", grant, 0);
        chk("rst_burst_err", burst_err, 0);
        chk("rst_s_rready", s_if.rready, 0);
        chk("rst_m0_rvalid", m0_if.rvalid, 0);
        chk("rst_m1_rvalid", m1_if.rvalid, 0);
        chk("rst_m0_arready", m0_if.arready, 0);
        chk("rst_arlock", s_if.arlock, 0);
        aresetn = 1'b1;
        step;

        // Tie, first AR stalled 5 cycles downstream
        req(0, 32'h0000_1000, 4'd7);
        req(1, 32'h0000_2000, 4'd0);
        w1 = RR ? 1'b0 : 1'b1;
        ar_accept(w1, w1 ? 32'h0000_2000 : 32'h0000_1000, w1 ? 4'd0 : 4'd7, 5);
        burst(w1, w1 ? 0 : 7, 8'h10);
        // Winner re-requests: second tie goes to M1 in both builds
        req(w1, w1 ? 32'h0000_2000 : 32'h0000_1000, w1 ? 4'd0 : 4'd7);
        ar_accept(1, 32'h0000_2000, 4'd0, 0);
        burst(1, 0, 8'h20);
        ar_accept(0, 32'h0000_1000, 4'd7, 0);
        burst(0, 7, 8'h30);

        // Single M0 request
        req(0, 32'h1FC0_0000, 4'd3);
        ar_accept(0, 32'h1FC0_0000, 4'd3, 0);
        burst(0, 3, 8'h40);
        chk("clean_burst_err", burst_err, 0);

        // rready toggling 1,0,1,0...
        req(0, 32'h1FC0_0100, 4'd3);
        ar_accept(0, 32'h1FC0_0100, 4'd3, 0);
        idx = 0;
        for (int c = 0; c < 16 && idx < 4; c++) begin
            m0_if.rready = (c % 2 == 0);
            s_if.rvalid  = 1'b1;
            s_if.rdata   = 32'h50 + idx;
            s_if.rlast   = (idx == 3);
            #1;
            chk("s_rready_mirror", s_if.rready, m0_if.rready);
            chk("rdata_order", m0_if.rdata, 32'h50 + idx);
            step;
            if (m0_if.rready) idx++;
        end
        chk("toggle_beats", idx, 4);
        chk("toggle_idle", idle, 1);
        s_if.rvalid = 0; s_if.rlast = 0; m0_if.rready = 1;

        // Early rlast on beat 2 of arlen=3
        req(0, 32'h1FC0_0200, 4'd3);
        ar_accept(0, 32'h1FC0_0200, 4'd3, 0);
        burst(0, 1, 8'h60);
        chk("early_rlast_err", burst_err, 1);
        req(1, 32'h2000_0000, 4'd0);
        ar_accept(1, 32'h2000_0000, 4'd0, 0);
        burst(1, 0, 8'h70);
        chk("err_sticky", burst_err, 1);

        // Reset during beat 2
        req(1, 32'h2000_0100, 4'd3);
        ar_accept(1, 32'h2000_0100, 4'd3, 0);
        m1_if.rready = 1;
        s_if.rvalid = 1; s_if.rdata = 32'h80; s_if.rlast = 0;
        step;
        s_if.rdata = 32'h81;
        aresetn = 1'b0;
        step;
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_s_arvalid", s_if.arvalid, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_burst_err", burst_err, 0);
        chk("mid_rst_s_araddr", s_if.araddr, 0);
        chk("mid_rst_m1_rvalid", m1_if.rvalid, 0);
        chk("mid_rst_m1_rdata", m1_if.rdata, 0);
        chk("mid_rst_s_rready", s_if.rready, 0);
        aresetn = 1'b1;
        s_if.rvalid = 0;
        step;
        req(1, 32'h2000_0200, 4'd1);
        ar_accept(1, 32'h2000_0200, 4'd1, 0);
        burst(1, 1, 8'h90);
        chk("post_rst_err", burst_err, 0);

        // Beat without rlast when count already 0
        req(1, 32'h2000_0300, 4'd0);
        ar_accept(1, 32'h2000_0300, 4'd0, 0);
        burst(1, 1, 8'hA0);
        chk("overrun_err", burst_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
